// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: RV32 byte-lane data memory with valid/ready handshake, registered load and error flag.
// Define DM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module data_memory_bytelane #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic MemRead,
  input  logic MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0] wd,
  input  logic [2:0] Funct3,
  output logic [DATA_W-1:0] rd,
  output logic resp_valid,
  output logic err
);
  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
  if (DATA_W != 32) begin : g_bad_width
    $error("data_memory_bytelane: DATA_W must be 32");
  end
  typedef enum logic {IDLE, RD} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DM_ADDRESS-1:0] la;
  logic [2:0] lf;
  logic accept, is_load, is_store, st_bad, ld_bad, st_mis, ld_mis;
  logic [1:0] st_lane, ld_lane;
  logic [3:0] we;
  logic [DATA_W-1:0] wdata, word, ld_data;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  function automatic logic [1:0] align(input logic [2:0] f, input logic [1:0] l);
    return f[1:0] == 2'b01 ? {l[1], 1'b0} : f[1:0] == 2'b10 ? 2'b00 : l;
  endfunction
`ifdef DM_MISALIGN_TRAP_EN
  function automatic logic misal(input logic [2:0] f, input logic [1:0] l);
    return (f[1:0] == 2'b01 && l[0]) || (f[1:0] == 2'b10 && l != 2'b00);
  endfunction
  assign st_mis = misal(Funct3, a[1:0]);
  assign ld_mis = misal(lf, la[1:0]);
`else
  assign st_mis = 1'b0;
  assign ld_mis = 1'b0;
`endif
  assign req_ready = state == IDLE;
  assign accept = req_valid & req_ready & (MemRead | MemWrite);
  assign is_load = accept & MemRead;
  assign is_store = accept & MemWrite & ~MemRead;
  assign st_bad = Funct3 > 3'b010 || st_mis;
  assign ld_bad = lf == 3'b011 || lf[2:1] == 2'b11 || ld_mis;
  assign st_lane = align(Funct3, a[1:0]);
  assign ld_lane = align(lf, la[1:0]);
  assign word = mem[la[DM_ADDRESS-1:2]];
  always_comb begin
    state_nx = state == IDLE && is_load ? RD : IDLE;
    we = Funct3 == 3'b000 ? 4'b0001 << st_lane :
         Funct3 == 3'b001 ? (st_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = Funct3 == 3'b000 ? {4{wd[7:0]}} : Funct3 == 3'b001 ? {2{wd[15:0]}} : wd;
    byte_v = ld_lane[1] ? (ld_lane[0] ? word[31:24] : word[23:16])
                        : (ld_lane[0] ? word[15:8] : word[7:0]);
    half_v = ld_lane[1] ? word[31:16] : word[15:0];
    ld_data = lf == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
              lf == 3'b001 ? {{16{half_v[15]}}, half_v} :
              lf == 3'b010 ? word :
              lf == 3'b100 ? {24'h0, byte_v} : {16'h0, half_v};
  end
  // Array has no reset; a store coinciding with rst is suppressed here.
  always_ff @(posedge clk)
    if (!rst && is_store && !st_bad)
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[a[DM_ADDRESS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rd <= '0;
      resp_valid <= 1'b0;
      err <= 1'b0;
      la <= '0;
      lf <= '0;
    end else begin
      state <= state_nx;
      resp_valid <= is_store || state == RD;
      if (is_load) begin
        la <= a;
        lf <= Funct3;
      end
      if (state == RD) begin
        err <= ld_bad;
        rd <= ld_bad ? '0 : ld_data;
      end else if (is_store) begin
        err <= st_bad;
        if (st_bad) rd <= '0;
      end else
        err <= 1'b0;
    end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: directed self-checking bench for data_memory_bytelane.
module tb_data_memory_bytelane;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [8:0] a = '0;
  logic [31:0] wd = '0;
  logic [2:0] Funct3 = '0;
  logic req_ready, resp_valid, err;
  logic [31:0] rd;
  int passed = 0, total = 0;
  logic rv0, rv, e;
  logic [31:0] d;

  data_memory_bytelane dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rd(rd), .resp_valid(resp_valid), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic do_store(input logic [8:0] addr, input logic [31:0] data, input logic [2:0] f3,
                          output logic srv, output logic se);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; a = addr; wd = data; Funct3 = f3;
    step();
    srv = resp_valid; se = err;
    idle();
  endtask

  task automatic do_load(input logic [8:0] addr, input logic [2:0] f3, input logic both,
                         output logic lrv0, output logic lrv, output logic [31:0] ld, output logic le);
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = both; a = addr; Funct3 = f3;
    wd = both ? 32'hFFFF_FFFF : 32'h0;
    step();
    lrv0 = resp_valid;
    idle();
    step();
    lrv = resp_valid; ld = rd; le = err;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step(); step();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL reset_rd got %h exp 00000000", rd); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp got %b exp 0", resp_valid); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_sw_lw();
    do_store(9'h010, 32'hDEAD_BEEF, 3'b010, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b0) $display("FAIL sw_resp got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL sw_ready got %b exp 1", req_ready); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (rv0 !== 1'b0) $display("FAIL lw_early_resp got %b exp 0", rv0); else passed++;
    total++; if (rv !== 1'b1 || e !== 1'b0) $display("FAIL lw_resp got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
    total++; if (d !== 32'hDEAD_BEEF) $display("FAIL lw_data got %h exp deadbeef", d); else passed++;
    step();
    total++; if (resp_valid !== 1'b0) $display("FAIL lw_pulse got %b exp 0", resp_valid); else passed++;
  endtask

  task automatic test_sb();
    do_store(9'h011, 32'h1234_56AA, 3'b000, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b0) $display("FAIL sb_resp got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hDEAD_AAEF) $display("FAIL sb_lw got %h exp deadaaef", d); else passed++;
    do_load(9'h011, 3'b000, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hFFFF_FFAA) $display("FAIL lb got %h exp ffffffaa", d); else passed++;
    do_load(9'h011, 3'b100, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h0000_00AA) $display("FAIL lbu got %h exp 000000aa", d); else passed++;
  endtask

  task automatic test_sh();
    do_store(9'h012, 32'h0000_8001, 3'b001, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b0) $display("FAIL sh_resp got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
    do_load(9'h012, 3'b001, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hFFFF_8001) $display("FAIL lh got %h exp ffff8001", d); else passed++;
    do_load(9'h012, 3'b101, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h0000_8001) $display("FAIL lhu got %h exp 00008001", d); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h8001_AAEF) $display("FAIL sh_lw got %h exp 8001aaef", d); else passed++;
  endtask

  task automatic test_misalign();
    do_load(9'h013, 3'b010, 1'b0, rv0, rv, d, e);
`ifdef DM_MISALIGN_TRAP_EN
    total++; if (rv !== 1'b1 || e !== 1'b1 || d !== 32'h0) $display("FAIL mis_lw got rv=%b err=%b rd=%h exp rv=1 err=1 rd=0", rv, e, d); else passed++;
    do_store(9'h012, 32'h0, 3'b010, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b1 || rd !== 32'h0) $display("FAIL mis_sw got rv=%b err=%b rd=%h exp rv=1 err=1 rd=0", rv, e, rd); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h8001_AAEF) $display("FAIL mis_word got %h exp 8001aaef", d); else passed++;
`else
    total++; if (rv !== 1'b1 || e !== 1'b0 || d !== 32'h8001_AAEF) $display("FAIL mis_lw got rv=%b err=%b rd=%h exp rv=1 err=0 rd=8001aaef", rv, e, d); else passed++;
    do_store(9'h012, 32'h0, 3'b010, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b0) $display("FAIL mis_sw got rv=%b err=%b exp rv=1 err=0", rv, e); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h0) $display("FAIL mis_word got %h exp 00000000", d); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    do_store(9'h010, 32'h1111_2222, 3'b010, rv, e);
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; a = 9'h010; Funct3 = 3'b010;
    step();
    total++; if (req_ready !== 1'b0) $display("FAIL b2b_busy got %b exp 0", req_ready); else passed++;
    MemRead = 1'b0; MemWrite = 1'b1; wd = 32'h3333_4444;
    step();
    total++; if (resp_valid !== 1'b1 || rd !== 32'h1111_2222) $display("FAIL b2b_load got rv=%b rd=%h exp rv=1 rd=11112222", resp_valid, rd); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready); else passed++;
    step();
    idle();
    total++; if (resp_valid !== 1'b1 || err !== 1'b0 || rd !== 32'h1111_2222) $display("FAIL b2b_store got rv=%b err=%b rd=%h exp rv=1 err=0 rd=11112222", resp_valid, err, rd); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h3333_4444) $display("FAIL b2b_after got %h exp 33334444", d); else passed++;
    req_valid = 1'b1; MemWrite = 1'b1; a = 9'h014; wd = 32'hAAAA_0001; Funct3 = 3'b010;
    step();
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) $display("FAIL ss_first got rv=%b ready=%b exp 1 1", resp_valid, req_ready); else passed++;
    a = 9'h018; wd = 32'hBBBB_0002;
    step();
    idle();
    total++; if (resp_valid !== 1'b1) $display("FAIL ss_second got %b exp 1", resp_valid); else passed++;
    do_load(9'h014, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hAAAA_0001) $display("FAIL ss_word0 got %h exp aaaa0001", d); else passed++;
    do_load(9'h018, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hBBBB_0002) $display("FAIL ss_word1 got %h exp bbbb0002", d); else passed++;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; a = 9'h010; Funct3 = 3'b010;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_rd got rv=%b ready=%b exp rv=0 ready=1", resp_valid, req_ready); else passed++;
    step();
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_no_resp got %b exp 0", resp_valid); else passed++;
    rst = 1'b1; req_valid = 1'b1; MemWrite = 1'b1; a = 9'h014; wd = 32'hDEAD_0000; Funct3 = 3'b010;
    step();
    rst = 1'b0; idle();
    do_load(9'h014, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'hAAAA_0001) $display("FAIL rst_store got %h exp aaaa0001", d); else passed++;
  endtask

  task automatic test_corner();
    do_load(9'h010, 3'b010, 1'b1, rv0, rv, d, e);
    total++; if (rv0 !== 1'b0 || rv !== 1'b1 || d !== 32'h3333_4444) $display("FAIL both_load got rv0=%b rv=%b rd=%h exp 0 1 33334444", rv0, rv, d); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h3333_4444) $display("FAIL both_nowrite got %h exp 33334444", d); else passed++;
    do_load(9'h010, 3'b111, 1'b0, rv0, rv, d, e);
    total++; if (rv !== 1'b1 || e !== 1'b1 || d !== 32'h0) $display("FAIL ill_load got rv=%b err=%b rd=%h exp 1 1 0", rv, e, d); else passed++;
    do_store(9'h010, 32'h0, 3'b011, rv, e);
    total++; if (rv !== 1'b1 || e !== 1'b1) $display("FAIL ill_store got rv=%b err=%b exp 1 1", rv, e); else passed++;
    do_load(9'h010, 3'b010, 1'b0, rv0, rv, d, e);
    total++; if (d !== 32'h3333_4444) $display("FAIL ill_nowrite got %h exp 33334444", d); else passed++;
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    step();
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL nop_req got rv=%b ready=%b exp 0 1", resp_valid, req_ready); else passed++;
    step();
    idle();
    total++; if (resp_valid !== 1'b0) $display("FAIL nop_req2 got %b exp 0", resp_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb();
    test_sh();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_corner();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
